uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter letting four byte-stream requesters share one UART transmitter.
// A grant is held for a whole packet and revoked if the owner goes quiet for too long.
module uart_tx_arbiter #(
    parameter logic [15:0] STALL_MAX = 16'd50000
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [3:0]  REQ_VALID,
    input  logic [31:0] REQ_DATA,
    input  logic [3:0]  REQ_LAST,
    output logic [3:0]  REQ_READY,
    output logic [3:0]  GRANT,
    output logic        BUSY,
    input  logic        TX_READY,
    output logic        TX_SEND,
    output logic [7:0]  TX_DATA
);

    localparam int unsigned NumReq = 4;
    localparam int unsigned IdxW   = 2;
    localparam int unsigned ByteW  = 8;
    localparam int unsigned StallW = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [IdxW-1:0]     ptr;
    logic [IdxW-1:0]     grantIdx;
    logic [IdxW-1:0]     pickIdx;
    logic                pickValid;
    logic                lastQ;
    logic [StallW-1:0]   stallCnt;
    logic [StallW-1:0]   stallInc;
    logic                stallHit;
    logic                grantValid;
    logic                grantLast;
    logic [ByteW-1:0]    grantData;
    logic                xfer;

    // Offset NumReq wraps to ptr itself, so iterating downward leaves the nearest index after ptr.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = ptr;
        for (int unsigned i = NumReq; i > 0; i--) begin
            if (REQ_VALID[IdxW'(ptr + IdxW'(i))]) begin
                pickValid = 1'b1;
                pickIdx   = IdxW'(ptr + IdxW'(i));
            end
        end
    end

    always_comb begin
        grantValid = REQ_VALID[grantIdx];
        grantLast  = REQ_LAST[grantIdx];
        grantData  = REQ_DATA[{grantIdx, 3'b000} +: ByteW];
        xfer       = (state == LOAD) && grantValid && TX_READY;
        stallInc   = (stallCnt == '1) ? stallCnt : StallW'(stallCnt + StallW'(1));
        stallHit   = (STALL_MAX != '0) && (stallInc >= STALL_MAX);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:      if (pickValid) stateNext = LOAD;
            LOAD: begin
                if (xfer) begin
                    stateNext = SEND;
                end else if (!grantValid && stallHit) begin
                    stateNext = IDLE;
                end
            end
            SEND:      stateNext = WAIT_BUSY;
            WAIT_BUSY: if (!TX_READY) stateNext = WAIT_DONE;
            WAIT_DONE: if (TX_READY) stateNext = lastQ ? IDLE : LOAD;
            default:   stateNext = IDLE;
        endcase
    end

    always_comb begin
        REQ_READY = '0;
        if (state == LOAD) begin
            REQ_READY[grantIdx] = TX_READY;
        end
        BUSY = (state != IDLE);
    end

    // Grant, pointer, stall counter and transmitter-side registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ptr      <= IdxW'(3);
            grantIdx <= '0;
            GRANT    <= '0;
            TX_SEND  <= 1'b0;
            TX_DATA  <= '0;
            lastQ    <= 1'b0;
            stallCnt <= '0;
        end else begin
            TX_SEND <= (stateNext == SEND);
            unique case (state)
                IDLE: begin
                    if (pickValid) begin
                        GRANT    <= NumReq'(1) << pickIdx;
                        grantIdx <= pickIdx;
                        stallCnt <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        TX_DATA  <= grantData;
                        lastQ    <= grantLast;
                        stallCnt <= '0;
                    end else if (!grantValid) begin
                        stallCnt <= stallInc;
                        if (stallHit) begin
                            ptr   <= grantIdx;
                            GRANT <= '0;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (TX_READY && lastQ) begin
                        ptr   <= grantIdx;
                        GRANT <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
